data_bus_interface: RTL and testbench
=====================================

# data_bus_interface

Memory-stage bus adapter between the MEM stage of the five-stage pipeline and an external, variable-latency data memory. It turns the single-cycle load/store request that `MemStage` presents into a registered request/acknowledge bus transaction. While the transaction is outstanding it drives a pipeline-wide stall. Read data is returned through a register so the MEM/WB registers capture it on the cycle the stall releases.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: number of cycles spent waiting in REQUEST without an acknowledge before the access is aborted. Legal range 1..255.

Ports:
- `clock`  input  1  — single clock; all state changes on the rising edge.
- `reset`  input  1  — asynchronous, active-low.
- `shouldReadMemory`  input  1  — MEM-stage load request.
- `shouldWriteMemory`  input  1  — MEM-stage store request.
- `address`  input  32  — byte address (ALU output).
- `writeData`  input  32  — store data (register Rt).
- `readData`  output  32  — registered load result.
- `shouldStall`  output  1  — holds every pipeline register and the PC while high.
- `busRequest`  output  1  — transaction valid.
- `busWriteEnable`  output  1  — 1 means write, 0 means read; valid while `busRequest` is high.
- `busAddress`  output  32  — word address, with bits [1:0] forced to 0.
- `busWriteData`  output  32  — store data.
- `busAcknowledge`  input  1  — one-cycle completion pulse from memory.
- `busReadData`  input  32  — valid in the same cycle as `busAcknowledge`.
- `busErrorFlag`  output  1  — sticky flag for a timeout or a misaligned access.

## Operation

- FSM states: IDLE, REQUEST, DONE, ABORT.
- **IDLE**
  - If `shouldWriteMemory` or `shouldReadMemory` is high, latch `address`, `writeData` and kind. If both are high, the access is a write.
  - Then go to REQUEST and clear the timeout counter.
  - Otherwise stay in IDLE.
- **REQUEST**
  - `busRequest` is 1. The bus outputs come from the latched values and stay stable until the acknowledge.
  - On `busAcknowledge`: for a read, load `readData` from `busReadData`; for a write, `readData` is unchanged. Go to DONE.
  - If there is no acknowledge, increment the counter. When the counter equals `TIMEOUT_CYCLES - 1`, go to ABORT in that same cycle. Acknowledge has priority over timeout in the same cycle.
- **DONE**: `busRequest` is 0. Go to IDLE unconditionally.
- **ABORT**
  - `busRequest` is 0 and `busErrorFlag` is set.
  - `readData` is loaded with 32'h0000_0000 for a read and unchanged for a write.
  - Go to IDLE unconditionally.
- **Misaligned access** (`address[1:0] != 0`):
  - The bus transaction still proceeds at the word-aligned address.
  - `busErrorFlag` is set when the access is latched in IDLE.
- **`shouldStall`** is combinational: (IDLE and (read or write)) or REQUEST. It is low in DONE and ABORT, so the pipeline advances at the end of those cycles.
- Behaviour in other states:
  - `busAcknowledge` arriving in IDLE, DONE or ABORT is ignored.
  - Changes on the request inputs during REQUEST are ignored.
- Because the pipeline is stalled, the same request is still present in DONE/ABORT. It is not re-issued: the return to IDLE happens on the edge where the pipeline advances.
- **Reset**: when `reset` is low, go to IDLE immediately, asynchronously and even in the middle of a transaction. All registered outputs are cleared:
  - `readData` = 0
  - `busRequest` = 0
  - `busWriteEnable` = 0
  - `busAddress` = 0
  - `busWriteData` = 0
  - `busErrorFlag` = 0

## Timing

- A request first visible in cycle N (IDLE) gives `shouldStall` = 1 in cycle N and `busRequest` = 1 from cycle N+1.
- With a zero-wait acknowledge in cycle N+1:
  - DONE in N+2, with `readData` valid and `shouldStall` = 0.
  - The pipeline advances at the end of N+2.
  - Minimum stall is 2 cycles.
- With an acknowledge after k wait cycles, the stall lasts 2+k cycles.
- Timeout: with no acknowledge, `busRequest` stays high for exactly `TIMEOUT_CYCLES` cycles. ABORT follows in the next cycle, and `busErrorFlag` rises at the start of ABORT.
- Back-to-back accesses: the next access can issue from IDLE in the cycle after DONE, giving `busRequest` low for exactly 2 cycles between them.
- `busRequest` changes only on clock edges. Nothing is combinational from bus inputs to bus outputs.

## Test plan

- **Reset:** with `reset` = 0, every output is 0. Release reset, hold no request → IDLE, `shouldStall` = 0.
- **Zero-wait load:** load at address 0x0000_0010 with memory acknowledging immediately and returning 0xCAFE_F00D → `busAddress` = 0x10 and `busWriteEnable` = 0 in N+1; `readData` = 0xCAFE_F00D and `shouldStall` = 0 in N+2; stall lasts 2 cycles.
- **Store, both requests high:** store with both read and write high, data 0x1234_5678 at 0x0000_0020, acknowledge after 3 wait cycles → `busWriteEnable` = 1; `busRequest` high for 4 cycles; `readData` unchanged; stall lasts 5 cycles.
- **Timeout:** `TIMEOUT_CYCLES` = 4 and acknowledge never arrives → `busRequest` high for 4 cycles, then ABORT with `readData` = 0 and `busErrorFlag` = 1 (it stays 1 through later good accesses).
- **Reset mid-transaction:** assert `reset` low during REQUEST → `busRequest` = 0 asynchronously. After release, a stray acknowledge pulse does not change `readData`.
- **Misaligned access:** load at 0x0000_0013 → `busAddress` = 0x0000_0010 and `busErrorFlag` = 1. A second acknowledge pulse in DONE is ignored.

Source files
------------

// File: rtl/data_bus_interface.sv
`default_nettype none
// ============================================================================
// data_bus_interface : MEM-stage load/store to registered req/ack bus adapter
// Revision 1.0
// ============================================================================
module data_bus_interface #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        shouldReadMemory,
    input  logic        shouldWriteMemory,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        shouldStall,
    output logic        busRequest,
    output logic        busWriteEnable,
    output logic [31:0] busAddress,
    output logic [31:0] busWriteData,
    input  logic        busAcknowledge,
    input  logic [31:0] busReadData,
    output logic        busErrorFlag
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_DONE    = 2'd2,
        S_ABORT   = 2'd3
    } state_t;

    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  count_q;
    logic [31:0] readData_q;
    logic        busRequest_q;
    logic        busWriteEnable_q;
    logic [31:0] busAddress_q;
    logic [31:0] busWriteData_q;
    logic        busErrorFlag_q;

    logic w_access;
    logic w_misaligned;
    logic w_timeout;

    assign w_access     = shouldReadMemory | shouldWriteMemory;
    assign w_misaligned = (address[1:0] != 2'b00);
    assign w_timeout    = (count_q == C_TIMEOUT_LAST);

    // busWriteEnable_q doubles as the latched access kind for the whole transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            count_q          <= 8'd0;
            readData_q       <= 32'h0000_0000;
            busRequest_q     <= 1'b0;
            busWriteEnable_q <= 1'b0;
            busAddress_q     <= 32'h0000_0000;
            busWriteData_q   <= 32'h0000_0000;
            busErrorFlag_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_access) begin
                        busWriteEnable_q <= shouldWriteMemory;
                        busAddress_q     <= {address[31:2], 2'b00};
                        busWriteData_q   <= writeData;
                        busRequest_q     <= 1'b1;
                        count_q          <= 8'd0;
                        if (w_misaligned) begin
                            busErrorFlag_q <= 1'b1;
                        end
                        state_q <= S_REQUEST;
                    end
                end
                S_REQUEST: begin
                    if (busAcknowledge) begin
                        if (!busWriteEnable_q) begin
                            readData_q <= busReadData;
                        end
                        busRequest_q <= 1'b0;
                        state_q      <= S_DONE;
                    end else if (w_timeout) begin
                        if (!busWriteEnable_q) begin
                            readData_q <= 32'h0000_0000;
                        end
                        busRequest_q   <= 1'b0;
                        busErrorFlag_q <= 1'b1;
                        state_q        <= S_ABORT;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_ABORT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign shouldStall    = ((state_q == S_IDLE) && w_access) || (state_q == S_REQUEST);
    assign readData       = readData_q;
    assign busRequest     = busRequest_q;
    assign busWriteEnable = busWriteEnable_q;
    assign busAddress     = busAddress_q;
    assign busWriteData   = busWriteData_q;
    assign busErrorFlag   = busErrorFlag_q;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_interface.sv
`default_nettype none
// ============================================================================
// tb_data_bus_interface : directed vectors for data_bus_interface (timeout 4)
// Revision 1.0
// ============================================================================
module tb_data_bus_interface;

    logic        clock;
    logic        reset;
    logic        shouldReadMemory;
    logic        shouldWriteMemory;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        shouldStall;
    logic        busRequest;
    logic        busWriteEnable;
    logic [31:0] busAddress;
    logic [31:0] busWriteData;
    logic        busAcknowledge;
    logic [31:0] busReadData;
    logic        busErrorFlag;

    int vectors;
    int miscompares;

    data_bus_interface #(.TIMEOUT_CYCLES(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .shouldReadMemory  (shouldReadMemory),
        .shouldWriteMemory (shouldWriteMemory),
        .address           (address),
        .writeData         (writeData),
        .readData          (readData),
        .shouldStall       (shouldStall),
        .busRequest        (busRequest),
        .busWriteEnable    (busWriteEnable),
        .busAddress        (busAddress),
        .busWriteData      (busWriteData),
        .busAcknowledge    (busAcknowledge),
        .busReadData       (busReadData),
        .busErrorFlag      (busErrorFlag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        reset             = 1'b0;
        shouldReadMemory  = 1'b0;
        shouldWriteMemory = 1'b0;
        address           = 32'h0;
        writeData         = 32'h0;
        busAcknowledge    = 1'b0;
        busReadData       = 32'h0;

        // Reset state
        #3;
        check("rst_readData", readData, 32'h0);
        check("rst_stall", {31'd0, shouldStall}, 32'd0);
        check("rst_req", {31'd0, busRequest}, 32'd0);
        check("rst_we", {31'd0, busWriteEnable}, 32'd0);
        check("rst_addr", busAddress, 32'h0);
        check("rst_wdata", busWriteData, 32'h0);
        check("rst_err", {31'd0, busErrorFlag}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_stall", {31'd0, shouldStall}, 32'd0);
        check("idle_req", {31'd0, busRequest}, 32'd0);

        // Zero-wait load at 0x10
        shouldReadMemory = 1'b1;
        address          = 32'h0000_0010;
        #1;
        check("ld_N_stall", {31'd0, shouldStall}, 32'd1);
        check("ld_N_req", {31'd0, busRequest}, 32'd0);
        tick();
        check("ld_N1_req", {31'd0, busRequest}, 32'd1);
        check("ld_N1_addr", busAddress, 32'h0000_0010);
        check("ld_N1_we", {31'd0, busWriteEnable}, 32'd0);
        check("ld_N1_stall", {31'd0, shouldStall}, 32'd1);
        busAcknowledge = 1'b1;
        busReadData    = 32'hCAFE_F00D;
        tick();
        busAcknowledge = 1'b0;
        check("ld_N2_rdata", readData, 32'hCAFE_F00D);
        check("ld_N2_stall", {31'd0, shouldStall}, 32'd0);
        check("ld_N2_req", {31'd0, busRequest}, 32'd0);
        shouldReadMemory = 1'b0;
        tick();
        check("ld_idle_stall", {31'd0, shouldStall}, 32'd0);

        // Store with both requests high, ack after 3 wait cycles
        shouldReadMemory  = 1'b1;
        shouldWriteMemory = 1'b1;
        address           = 32'h0000_0020;
        writeData         = 32'h1234_5678;
        #1;
        check("st_N_stall", {31'd0, shouldStall}, 32'd1);
        tick();
        check("st_we", {31'd0, busWriteEnable}, 32'd1);
        check("st_addr", busAddress, 32'h0000_0020);
        check("st_wdata", busWriteData, 32'h1234_5678);
        check("st_req1", {31'd0, busRequest}, 32'd1);
        tick();
        check("st_req2", {31'd0, busRequest}, 32'd1);
        check("st_stall2", {31'd0, shouldStall}, 32'd1);
        tick();
        check("st_req3", {31'd0, busRequest}, 32'd1);
        tick();
        check("st_req4", {31'd0, busRequest}, 32'd1);
        check("st_stall4", {31'd0, shouldStall}, 32'd1);
        busAcknowledge = 1'b1;
        busReadData    = 32'hDEAD_BEEF;
        tick();
        busAcknowledge = 1'b0;
        check("st_done_req", {31'd0, busRequest}, 32'd0);
        check("st_done_stall", {31'd0, shouldStall}, 32'd0);
        check("st_rdata_kept", readData, 32'hCAFE_F00D);
        check("st_err", {31'd0, busErrorFlag}, 32'd0);
        shouldReadMemory  = 1'b0;
        shouldWriteMemory = 1'b0;
        tick();

        // Timeout: load at 0x30, no acknowledge
        shouldReadMemory = 1'b1;
        address          = 32'h0000_0030;
        tick();
        check("to_req1", {31'd0, busRequest}, 32'd1);
        tick();
        check("to_req2", {31'd0, busRequest}, 32'd1);
        tick();
        check("to_req3", {31'd0, busRequest}, 32'd1);
        tick();
        check("to_req4", {31'd0, busRequest}, 32'd1);
        check("to_err_pre", {31'd0, busErrorFlag}, 32'd0);
        tick();
        check("to_abort_req", {31'd0, busRequest}, 32'd0);
        check("to_abort_rdata", readData, 32'h0);
        check("to_abort_err", {31'd0, busErrorFlag}, 32'd1);
        check("to_abort_stall", {31'd0, shouldStall}, 32'd0);
        shouldReadMemory = 1'b0;
        tick();

        // Good load after the timeout keeps the sticky flag
        shouldReadMemory = 1'b1;
        address          = 32'h0000_0040;
        tick();
        busAcknowledge = 1'b1;
        busReadData    = 32'h55AA_55AA;
        tick();
        busAcknowledge = 1'b0;
        check("post_to_rdata", readData, 32'h55AA_55AA);
        check("post_to_err", {31'd0, busErrorFlag}, 32'd1);
        shouldReadMemory = 1'b0;
        tick();

        // Reset in the middle of a transaction
        shouldReadMemory = 1'b1;
        address          = 32'h0000_0050;
        tick();
        check("mid_req", {31'd0, busRequest}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, busRequest}, 32'd0);
        check("mid_rst_err", {31'd0, busErrorFlag}, 32'd0);
        check("mid_rst_rdata", readData, 32'h0);
        shouldReadMemory = 1'b0;
        #1;
        reset = 1'b1;
        busAcknowledge = 1'b1;
        busReadData    = 32'hFFFF_FFFF;
        tick();
        busAcknowledge = 1'b0;
        check("stray_ack_rdata", readData, 32'h0);
        check("stray_ack_req", {31'd0, busRequest}, 32'd0);

        // Misaligned load at 0x13, second ack pulse in DONE
        shouldReadMemory = 1'b1;
        address          = 32'h0000_0013;
        tick();
        check("mis_addr", busAddress, 32'h0000_0010);
        check("mis_err", {31'd0, busErrorFlag}, 32'd1);
        busAcknowledge = 1'b1;
        busReadData    = 32'h0BAD_F00D;
        tick();
        check("mis_rdata", readData, 32'h0BAD_F00D);
        busReadData      = 32'h1111_1111;
        shouldReadMemory = 1'b0;
        tick();
        busAcknowledge = 1'b0;
        check("mis_ack2_rdata", readData, 32'h0BAD_F00D);
        check("mis_ack2_req", {31'd0, busRequest}, 32'd0);
        check("mis_ack2_stall", {31'd0, shouldStall}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
